// File: rtl/demosaic_frame_ctrl.sv
// Frame sequencer for the demosaic datapath: pops Bayer pixels, drives window shifts, flushes the
// last row, and flags frame start/end. Optional statistics outputs under DEMOSAIC_CTRL_STAT_EN.
module demosaic_frame_ctrl #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned CNT_W = 12,
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_en,
  input  logic             fifo_not_empty,
  output logic             fifo_ren,
  input  logic [PIX_W-1:0] fifo_din,
  input  logic             demosaic_i_ready,
  output logic [PIX_W-1:0] pix_out,
  output logic             shift_en,
  output logic             count_en,
  output logic             sof,
  output logic             eof,
  output logic             busy
`ifdef DEMOSAIC_CTRL_STAT_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int unsigned SHIFT_W = CNT_W + 1;

  localparam logic [CNT_W-1:0]   ColLast   = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0]   RowLast   = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0]   FlushLast = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0]   CntOne    = CNT_W'(1);
  // Window centre first holds a real pixel once a full row plus one pixel has been shifted in.
  localparam logic [SHIFT_W-1:0] ShiftThr  = SHIFT_W'(IMG_W + 1);
  localparam logic [SHIFT_W-1:0] ShiftOne  = SHIFT_W'(1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]   col_q, col_d;
  logic [CNT_W-1:0]   row_q, row_d;
  logic [CNT_W-1:0]   flush_q, flush_d;
  logic [SHIFT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic               xfer;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (frame_en) state_d = StRun;
      end
      StRun: begin
        if (xfer && (col_q == ColLast) && (row_q == RowLast)) state_d = StFlush;
      end
      StFlush: begin
        if (shift_en && (flush_q == FlushLast)) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: handshakes are combinational so pops and shifts have zero latency.
  always_comb begin
    xfer     = 1'b0;
    fifo_ren = 1'b0;
    shift_en = 1'b0;
    pix_out  = '0;
    sof      = 1'b0;
    eof      = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      StRun: begin
        xfer     = fifo_not_empty & demosaic_i_ready;
        fifo_ren = xfer;
        shift_en = xfer;
        pix_out  = fifo_din;
        busy     = 1'b1;
        sof      = xfer & (col_q == '0) & (row_q == '0);
      end
      StFlush: begin
        shift_en = demosaic_i_ready;
        busy     = 1'b1;
      end
      StDone: begin
        eof = 1'b1;
      end
      default: ;
    endcase
    count_en = shift_en & (shift_cnt_q >= ShiftThr);
  end

  // Position, flush and shift counters
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    flush_d     = flush_q;
    shift_cnt_d = shift_cnt_q;

    if (shift_en && (shift_cnt_q < ShiftThr)) shift_cnt_d = shift_cnt_q + ShiftOne;

    unique case (state_q)
      StRun: begin
        if (xfer) begin
          if (col_q == ColLast) begin
            col_d = '0;
            row_d = (row_q == RowLast) ? '0 : row_q + CntOne;
          end else begin
            col_d = col_q + CntOne;
          end
        end
      end
      StFlush: begin
        if (shift_en) flush_d = (flush_q == FlushLast) ? '0 : flush_q + CntOne;
      end
      StDone: begin
        col_d       = '0;
        row_d       = '0;
        flush_d     = '0;
        shift_cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      flush_q     <= '0;
      shift_cnt_q <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      flush_q     <= flush_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

`ifdef DEMOSAIC_CTRL_STAT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (eof) frame_cnt_d = frame_cnt_q + 16'd1;
    if (sof) begin
      stall_cnt_d = '0;
    end else if (busy && !demosaic_i_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_demosaic_frame_ctrl.sv
// Directed bench for demosaic_frame_ctrl at IMG_W=4, IMG_H=3 (17 shifts, 12 pixels per frame).
module tb_demosaic_frame_ctrl;
  localparam int unsigned IMG_W = 4;
  localparam int unsigned IMG_H = 3;
  localparam int unsigned CNT_W = 12;
  localparam int unsigned PIX_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_en = 1'b0;
  logic             fifo_not_empty = 1'b0;
  logic             fifo_ren;
  logic [PIX_W-1:0] fifo_din = 8'h40;
  logic             demosaic_i_ready = 1'b0;
  logic [PIX_W-1:0] pix_out;
  logic             shift_en;
  logic             count_en;
  logic             sof;
  logic             eof;
  logic             busy;
`ifdef DEMOSAIC_CTRL_STAT_EN
  logic [15:0]      frame_cnt;
  logic [15:0]      stall_cnt;
`endif

  demosaic_frame_ctrl #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .CNT_W(CNT_W),
    .PIX_W(PIX_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_en        (frame_en),
    .fifo_not_empty  (fifo_not_empty),
    .fifo_ren        (fifo_ren),
    .fifo_din        (fifo_din),
    .demosaic_i_ready(demosaic_i_ready),
    .pix_out         (pix_out),
    .shift_en        (shift_en),
    .count_en        (count_en),
    .sof             (sof),
    .eof             (eof),
    .busy            (busy)
`ifdef DEMOSAIC_CTRL_STAT_EN
    ,
    .frame_cnt       (frame_cnt),
    .stall_cnt       (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_ren, n_shift, n_cnt, n_sof, n_eof, n_busy, viol;
  int first_cnt, sof_at, last_shift_cyc, eof_cyc, cyc;
  int gap_s0, gap_s1;
  logic [PIX_W-1:0] base;
  logic [PIX_W-1:0] pix_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_ren = 0; n_shift = 0; n_cnt = 0; n_sof = 0; n_eof = 0; n_busy = 0; viol = 0;
    first_cnt = 0; sof_at = 0; last_shift_cyc = 0; eof_cyc = 0; cyc = 0;
    pix_log.delete();
    base = fifo_din;
  endtask

  // Inputs are set just after a negedge; outputs are sampled 1 time unit later, before the posedge.
  task automatic tick();
    logic popped;
    #1;
    cyc++;
    if (shift_en) begin
      n_shift++;
      pix_log.push_back(pix_out);
      last_shift_cyc = cyc;
      if (count_en && first_cnt == 0) first_cnt = n_shift;
    end
    if (count_en) n_cnt++;
    if (count_en && !shift_en) viol++;
    if (fifo_ren) n_ren++;
    if (fifo_ren && !(fifo_not_empty && demosaic_i_ready)) viol++;
    if (shift_en && !demosaic_i_ready) viol++;
    if (sof) begin
      n_sof++;
      sof_at = n_shift;
    end
    if (eof) begin
      n_eof++;
      eof_cyc = cyc;
    end
    if (busy) n_busy++;
    popped = fifo_ren;
    @(negedge clk);
    if (popped) fifo_din = fifo_din + 8'd1;
  endtask

  // mode 0: steady, 1: ready toggles, 2: FIFO gap mid line 1, 3: frame_en dropped after 3 pops
  task automatic run_frame(input int mode, input int stop_shift, input bit keep_en);
    int  c;
    bit  done;
    c = 0;
    done = 1'b0;
    frame_en = 1'b1;
    fifo_not_empty = 1'b1;
    demosaic_i_ready = 1'b1;
    while (!done && c < 200) begin
      if (mode == 1) demosaic_i_ready = (c % 2 == 0);
      if (mode == 2) fifo_not_empty = !(c >= 7 && c <= 16);
      if (mode == 3) frame_en = (n_ren < 3);
      tick();
      c++;
      if (c == 7) gap_s0 = n_shift;
      if (c == 17) gap_s1 = n_shift;
      if (n_eof > 0 || (stop_shift > 0 && n_shift >= stop_shift)) done = 1'b1;
    end
    check("frame_completes_in_budget", 32'(done), 32'd1);
    frame_en = keep_en;
    demosaic_i_ready = 1'b1;
  endtask

  task automatic check_frame(input string t);
    check({t, ".shifts"}, n_shift, 17);
    check({t, ".pops"}, n_ren, 12);
    check({t, ".count_en"}, n_cnt, 12);
    check({t, ".first_count_shift"}, first_cnt, 6);
    check({t, ".sof_count"}, n_sof, 1);
    check({t, ".sof_on_shift"}, sof_at, 1);
    check({t, ".eof_count"}, n_eof, 1);
    check({t, ".eof_after_last_shift"}, eof_cyc - last_shift_cyc, 1);
    check({t, ".handshake_violations"}, viol, 0);
    for (int i = 0; i < 17 && i < pix_log.size(); i++) begin
      logic [PIX_W-1:0] exp;
      exp = (i < 12) ? base + 8'(i) : 8'h00;
      check($sformatf("%s.pix%0d", t, i), 32'(pix_log[i]), 32'(exp));
    end
  endtask

  initial begin
    // Reset state
    #2;
    check("reset.outputs", 32'({fifo_ren, shift_en, count_en, sof, eof, busy, pix_out}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    fifo_not_empty = 1'b1;
    demosaic_i_ready = 1'b1;
    repeat (3) tick();
    check("idle_without_frame_en.shifts", n_shift, 0);
    check("idle_without_frame_en.busy", n_busy, 0);

    // 1: steady streaming
    clear_stats();
    run_frame(0, 0, 1'b0);
    check_frame("t1");
    check("t1.busy_cycles", n_busy, 17);

    // 2: ready toggling every cycle
    clear_stats();
    run_frame(1, 0, 1'b0);
    check_frame("t2");

    // 3: FIFO empty for 10 cycles after 6 pixels
    clear_stats();
    run_frame(2, 0, 1'b0);
    check_frame("t3");
    check("t3.shifts_before_gap", gap_s0, 6);
    check("t3.shifts_after_gap", gap_s1, 6);

    // 4: frame_en dropped after 3 pixels; frame still completes, then stays idle
    clear_stats();
    run_frame(3, 0, 1'b0);
    check_frame("t4");
    clear_stats();
    repeat (10) tick();
    check("t4.idle_shifts", n_shift, 0);
    check("t4.idle_busy", n_busy, 0);
    check("t4.idle_sof", n_sof, 0);

    // 5: asynchronous reset during FLUSH
    clear_stats();
    run_frame(0, 14, 1'b1);
    #1;
    check("t5.in_flush_shift", 32'(shift_en), 32'd1);
    check("t5.in_flush_pix", 32'(pix_out), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t5.reset_outputs", 32'({fifo_ren, shift_en, count_en, sof, eof, busy, pix_out}), 32'd0);
    frame_en = 1'b0;
    clear_stats();
    repeat (3) tick();
    check("t5.no_eof_after_abort", n_eof, 0);
    rst_n = 1'b1;
    clear_stats();
    run_frame(0, 0, 1'b0);
    check_frame("t5");

`ifdef DEMOSAIC_CTRL_STAT_EN
    // 6: three back-to-back frames, ready low for 4 cycles in frame 3
    rst_n = 1'b0;
    #1;
    check("t6.frame_cnt_reset", 32'(frame_cnt), 32'd0);
    check("t6.stall_cnt_reset", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    frame_en = 1'b1;
    fifo_not_empty = 1'b1;
    demosaic_i_ready = 1'b1;
    for (int c = 0; c < 300 && n_ren < 26; c++) tick();
    demosaic_i_ready = 1'b0;
    repeat (4) tick();
    demosaic_i_ready = 1'b1;
    for (int c = 0; c < 300 && n_eof < 3; c++) tick();
    frame_en = 1'b0;
    check("t6.eofs", n_eof, 3);
    check("t6.shifts", n_shift, 51);
    check("t6.frame_cnt", 32'(frame_cnt), 32'd3);
    check("t6.stall_cnt", 32'(stall_cnt), 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
